cpu_clk_ctrl: RTL

Clock-enable sequencer for the single-cycle CPU on the FPGA board. It replaces the free-running divided CPU clock with a one-`clk`-wide `cpu_ce` strobe. The strobe supports four behaviours: fast run, slow run, single-step from a debounced push button, and halt on a CPU halt request. It sits between the board switches and buttons and the CPU core, and exports a retired-cycle counter for the seven-segment display.

---
 rtl/cpu_clk_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: fast/slow free run, debounced single-step and halt,
// emitting a one-clk cpu_ce strobe and counting retired CPU cycles.
module cpu_clk_ctrl #(
    parameter int FAST_DIV  = 8,
    parameter int SLOW_DIV  = 67108864,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SW15,
    input  logic             sw_step,
    input  logic             btn_step,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STEP_WAIT  = 2'd1,
        STEP_PULSE = 2'd2,
        HALTED     = 2'd3
    } state_e;

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int PW      = $clog2(MAX_DIV);
    localparam int DW      = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] FAST_M1 = PW'(FAST_DIV - 1);
    localparam logic [PW-1:0] SLOW_M1 = PW'(SLOW_DIV - 1);
    localparam logic [DW-1:0] DB_M1   = DW'(DB_CYCLES - 1);

    // Synchroniser bit order: {btn_step, sw_step, SW15}
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0]    db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             step_evt_q, step_evt_d;
    logic [PW-1:0]    presc_q, presc_d;
    state_e           state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic          sw15_s, step_s, btn_s, rate_chg, at_top;
    logic [PW-1:0] div_m1;

    assign sw15_s   = sync2_q[0];
    assign step_s   = sync2_q[1];
    assign btn_s    = sync2_q[2];
    assign rate_chg = sync1_q[0] ^ sync2_q[0];
    assign div_m1   = sw15_s ? SLOW_M1 : FAST_M1;
    assign at_top   = (presc_q == div_m1);

    always_comb begin
        sync1_d      = {btn_step, sw_step, SW15};
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        db_cnt_d     = db_cnt_q + DW'(1);
        stable_dly_d = stable_q;
        // Event is taken one cycle after stable rises so it lines up with the registered FSM.
        step_evt_d   = stable_q & ~stable_dly_q;
        if (btn_s == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_M1) begin
            stable_d = btn_s;
            db_cnt_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_ce_d    = 1'b0;
        presc_d     = '0;
        cycle_cnt_d = cpu_ce_q ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
        unique case (state_q)
            RUN: begin
                if (cpu_ce_q && halt_req) begin
                    state_d = HALTED;
                end else if (step_s) begin
                    state_d = STEP_WAIT;
                end else if (rate_chg) begin
                    presc_d = '0;
                end else if (at_top) begin
                    cpu_ce_d = 1'b1;
                    presc_d  = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            STEP_WAIT: begin
                if (!step_s) begin
                    state_d = RUN;
                end else if (step_evt_q) begin
                    state_d  = STEP_PULSE;
                    cpu_ce_d = 1'b1;
                end
            end
            STEP_PULSE: begin
                if (halt_req)    state_d = HALTED;
                else if (step_s) state_d = STEP_WAIT;
                else             state_d = RUN;
            end
            HALTED: begin
                if (step_evt_q) state_d = step_s ? STEP_WAIT : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_cnt_q     <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            step_evt_q   <= 1'b0;
            presc_q      <= '0;
            state_q      <= RUN;
            cpu_ce_q     <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            step_evt_q   <= step_evt_d;
            presc_q      <= presc_d;
            state_q      <= state_d;
            cpu_ce_q     <= cpu_ce_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
